core_boot_sequencer: RTL and testbench

- Boot/reload controller for the single-cycle RISC-V core.
- Holds the core in reset and assembles a byte stream into 32-bit words.
- Writes those words into instruction memory through the core's in-system-programmer port (isp_address/isp_data/isp_write).
- Then releases core reset and issues a one-cycle start pulse with the program entry address.
- Sits between the external loader (UART/SPI byte source) and the core's clock-domain control inputs.

---
 rtl/core_boot_sequencer.sv | 169 ++++++++++++++++
 tb/tb_core_boot_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_boot_sequencer.sv
// Boot/reload controller: holds the core in reset, packs a byte stream into words,
// writes them through the ISP port, then releases the core and pulses start.
module core_boot_sequencer #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 8,
   parameter int START_DELAY  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_req,
   input  logic [ADDRESS_BITS-1:0] load_base,
   input  logic [ADDRESS_BITS-1:0] load_count,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_ready,
   output logic [ADDRESS_BITS-1:0] isp_address,
   output logic [DATA_WIDTH-1:0]   isp_data,
   output logic                    isp_write,
   output logic                    core_reset,
   output logic                    core_start,
   output logic [ADDRESS_BITS-1:0] prog_address,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_RELEASE,
      ST_START,
      ST_RUN
   } state_t;

   localparam logic [3:0]              DELAY_INIT = 4'(START_DELAY);
   localparam logic [ADDRESS_BITS-1:0] ONE_WORD   = ADDRESS_BITS'(1);

   state_t                  state_q;
   logic [ADDRESS_BITS-1:0] base_q;
   logic [ADDRESS_BITS-1:0] remaining_q;
   logic [ADDRESS_BITS-1:0] idx_q;
   logic [1:0]              byte_cnt_q;
   logic [DATA_WIDTH-1:0]   word_q;
   logic [3:0]              delay_q;

   logic                    byte_ready_q;
   logic [ADDRESS_BITS-1:0] isp_address_q;
   logic [DATA_WIDTH-1:0]   isp_data_q;
   logic                    isp_write_q;
   logic                    core_reset_q;
   logic                    core_start_q;
   logic [ADDRESS_BITS-1:0] prog_address_q;
   logic                    busy_q;
   logic                    done_q;

   logic [DATA_WIDTH-1:0]   word_d;

   // Current word with the incoming byte merged in, so WRITE can publish the 4th byte.
   always_comb begin
      // NOTE: default assignment first so no path leaves word_d unassigned (no latch).
      word_d = word_q;
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         base_q         <= '0;
         remaining_q    <= '0;
         idx_q          <= '0;
         byte_cnt_q     <= '0;
         word_q         <= '0;
         delay_q        <= '0;
         byte_ready_q   <= 1'b0;
         isp_address_q  <= '0;
         isp_data_q     <= '0;
         isp_write_q    <= 1'b0;
         core_reset_q   <= 1'b1;
         core_start_q   <= 1'b0;
         prog_address_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         isp_write_q  <= 1'b0;
         core_start_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if (load_req) begin
                  base_q      <= load_base;
                  remaining_q <= load_count;
                  idx_q       <= '0;
                  byte_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  if (load_count == '0) begin
                     state_q      <= ST_RELEASE;
                     delay_q      <= DELAY_INIT;
                     // A running core still sees one reset cycle before the empty reboot.
                     core_reset_q <= (state_q == ST_RUN);
                  end else begin
                     state_q      <= ST_LOAD;
                     byte_ready_q <= 1'b1;
                     core_reset_q <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (byte_valid) begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     state_q       <= ST_WRITE;
                     byte_ready_q  <= 1'b0;
                     isp_write_q   <= 1'b1;
                     isp_address_q <= base_q + idx_q;
                     isp_data_q    <= word_d;
                  end
               end
            end

            ST_WRITE: begin
               idx_q       <= idx_q + ONE_WORD;
               remaining_q <= remaining_q - ONE_WORD;
               byte_cnt_q  <= '0;
               if (remaining_q == ONE_WORD) begin
                  state_q      <= ST_RELEASE;
                  core_reset_q <= 1'b0;
                  delay_q      <= DELAY_INIT;
               end else begin
                  state_q      <= ST_LOAD;
                  byte_ready_q <= 1'b1;
               end
            end

            ST_RELEASE: begin
               core_reset_q <= 1'b0;
               if (delay_q == 4'd0) begin
                  state_q        <= ST_START;
                  core_start_q   <= 1'b1;
                  prog_address_q <= base_q;
               end else begin
                  delay_q <= delay_q - 4'd1;
               end
            end

            ST_START: begin
               state_q <= ST_RUN;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign byte_ready   = byte_ready_q;
   assign isp_address  = isp_address_q;
   assign isp_data     = isp_data_q;
   assign isp_write    = isp_write_q;
   assign core_reset   = core_reset_q;
   assign core_start   = core_start_q;
   assign prog_address = prog_address_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Bench for core_boot_sequencer: table of boot scenarios plus reset/recovery sequences.
// Cycle offsets count clock edges after the edge that samples load_req.
module tb_core_boot_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_req = 1'b0;
   logic [7:0]  load_base = '0;
   logic [7:0]  load_count = '0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [7:0]  isp_address;
   logic [31:0] isp_data;
   logic        isp_write;
   logic        core_reset;
   logic        core_start;
   logic [7:0]  prog_address;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];

   typedef struct {
      logic [7:0]  base;
      logic [7:0]  count;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      int          intrude;
      logic [7:0]  a0;
      logic [7:0]  a1;
      int          wc0;
      int          wc1;
      int          start_lat;
   } vec_t;

   vec_t vecs[5];

   core_boot_sequencer #(
      .DATA_WIDTH(32),
      .ADDRESS_BITS(8),
      .START_DELAY(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .load_req(load_req),
      .load_base(load_base),
      .load_count(load_count),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .isp_address(isp_address),
      .isp_data(isp_data),
      .isp_write(isp_write),
      .core_reset(core_reset),
      .core_start(core_start),
      .prog_address(prog_address),
      .busy(busy),
      .done(done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (reset && isp_write) begin
         wa_q.push_back(isp_address);
         wd_q.push_back(isp_data);
         wc_q.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_core_reset"}, core_reset, 1);
      check({tag, "_core_start"}, core_start, 0);
      check({tag, "_isp_write"}, isp_write, 0);
      check({tag, "_isp_address"}, isp_address, 0);
      check({tag, "_isp_data"}, isp_data, 0);
      check({tag, "_byte_ready"}, byte_ready, 0);
      check({tag, "_prog_address"}, prog_address, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Called at a negedge; returns at the negedge after the load_req edge.
   task automatic do_load(input logic [7:0] base, input logic [7:0] count, output int c0);
      load_req   = 1'b1;
      load_base  = base;
      load_count = count;
      @(negedge clock);
      load_req = 1'b0;
      c0 = cyc;
   endtask

   // Presents a byte and returns at the negedge following the edge that accepts it.
   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      for (int g = 0; g < 50 && !byte_ready; g++) @(negedge clock);
      if (!byte_ready) check("byte_ready_timeout", byte_ready, 1);
      @(negedge clock);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int          c0;
      logic [31:0] wv[2];
      logic [7:0]  av[2];
      int          cv[2];
      wv[0] = v.w0; wv[1] = v.w1;
      av[0] = v.a0; av[1] = v.a1;
      cv[0] = v.wc0; cv[1] = v.wc1;
      wa_q.delete(); wd_q.delete(); wc_q.delete();

      do_load(v.base, v.count, c0);
      check($sformatf("v%0d_busy_after_req", id), busy, 1);
      check($sformatf("v%0d_done_after_req", id), done, 0);
      if (v.count != 0) check($sformatf("v%0d_core_reset_after_req", id), core_reset, 1);

      for (int w = 0; w < v.count; w++) begin
         for (int b = 0; b < 4; b++) begin
            send_byte(wv[w][8*b +: 8]);
            if (v.intrude != 0 && w == 0 && b == 0) begin
               load_req   = 1'b1;
               load_base  = 8'h77;
               load_count = 8'h00;
            end
            if (v.intrude != 0 && w == 0 && b == 1) load_req = 1'b0;
            if (v.gap > 0 && w == 0 && b == 1) begin
               byte_valid = 1'b0;
               repeat (v.gap) @(negedge clock);
            end
         end
      end
      byte_valid = 1'b0;

      for (int g = 0; g < 200 && !core_start; g++) @(negedge clock);
      check($sformatf("v%0d_start_seen", id), core_start, 1);
      check($sformatf("v%0d_start_latency", id), cyc - c0, v.start_lat);
      check($sformatf("v%0d_start_prog_address", id), prog_address, v.base);
      check($sformatf("v%0d_start_core_reset", id), core_reset, 0);
      @(negedge clock);
      check($sformatf("v%0d_start_one_cycle", id), core_start, 0);
      check($sformatf("v%0d_done", id), done, 1);
      check($sformatf("v%0d_busy_run", id), busy, 0);
      check($sformatf("v%0d_prog_address_hold", id), prog_address, v.base);

      check($sformatf("v%0d_write_count", id), wa_q.size(), v.count);
      for (int i = 0; i < v.count && i < 2 && i < wa_q.size(); i++) begin
         check($sformatf("v%0d_addr%0d", id, i), wa_q[i], av[i]);
         check($sformatf("v%0d_data%0d", id, i), wd_q[i], wv[i]);
         check($sformatf("v%0d_wcycle%0d", id, i), wc_q[i] - c0, cv[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      //          base   count  w0            w1            gap intr a0     a1     wc0 wc1 lat
      vecs[0] = '{8'h10, 8'd2, 32'h00000013, 32'h005000B3, 0,  0,  8'h10, 8'h11, 4,  9,  15};
      vecs[1] = '{8'h20, 8'd0, 32'h0,        32'h0,        0,  0,  8'h00, 8'h00, 0,  0,  5};
      vecs[2] = '{8'hFF, 8'd2, 32'hDEADBEEF, 32'h01234567, 0,  0,  8'hFF, 8'h00, 4,  9,  15};
      vecs[3] = '{8'h40, 8'd1, 32'hA5A55A5A, 32'h0,        7,  0,  8'h40, 8'h00, 11, 0,  17};
      vecs[4] = '{8'h30, 8'd1, 32'h11223344, 32'h0,        0,  1,  8'h30, 8'h00, 4,  0,  10};

      repeat (3) @(negedge clock);
      #1;
      check_reset_values("por");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("idle_core_reset", core_reset, 1);
      check("idle_busy", busy, 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Reset mid-LOAD must clear every output immediately, including held ISP values.
      do_load(8'h50, 8'd1, c0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      byte_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_values("midload");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("post_reset_byte_ready", byte_ready, 0);
      check("post_reset_busy", busy, 0);

      run_vec(vecs[0], 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
